// File: rtl/ip2_test3_sweep_ctrl.sv
// ip2_test3_sweep_ctrl
// Runs the IP2 test3 state machine repeatedly while sweeping the trigger-out
// phase from phase_start to phase_stop, and queues each run's DNN outputs,
// tagged with the phase, in a first-word-fall-through result FIFO.
// Optional build macro: IP2_TEST3_SWEEP_TIMEOUT_EN adds a WAIT_DONE watchdog
// (TIMEOUT_CYCLES) that ends the sweep through ERROR with sweep_timeout set.
module ip2_test3_sweep_ctrl #(
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset_not,
    input  logic                     enable,
    input  logic                     sweep_start,
    input  logic                     sweep_abort,
    input  logic [5:0]               phase_start,
    input  logic [5:0]               phase_stop,
    input  logic [5:0]               phase_step,
    input  logic [7:0]               repeat_count,
    output logic                     test2_enable_re,
    output logic [5:0]               test_trig_out_phase,
    input  logic                     sm_test3_o_status_done,
    input  logic [47:0]              sm_test3_o_dnn_output_0,
    input  logic [47:0]              sm_test3_o_dnn_output_1,
    input  logic                     fifo_rd_en,
    output logic [101:0]             fifo_rd_data,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     sweep_busy,
    output logic                     sweep_done,
    output logic                     sweep_timeout,
    output logic [15:0]              run_count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_DONE, S_PUSH, S_GAP, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t             state;
    logic               clr;
    logic               start_q;
    logic               done_q;
    logic               start_rise;
    logic               done_rise;
    logic [7:0]         rep;
    logic [7:0]         rep_max;
    logic [6:0]         nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               wd_expire;
    logic               push;
    logic               pop;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [101:0]       mem [DEPTH];

    assign clr        = !reset_not || !enable;
    assign start_rise = sweep_start && !start_q;
    assign done_rise  = sm_test3_o_status_done && !done_q;
    assign rep_max    = (repeat_count == 8'd0) ? 8'd1 : repeat_count;
    // 7-bit sum so that a phase overflow past 63 ends the sweep instead of wrapping
    assign nxt        = {1'b0, test_trig_out_phase} + {1'b0, phase_step};

    // Edge-detect history; loading the live level every cycle (reset included) means no false edge after reset
    always_ff @(posedge clk) begin
        start_q <= sweep_start;
        done_q  <= sm_test3_o_status_done;
    end

    // Sweep sequencer: launch, wait for done, push, gap, then advance repeat/phase
    always_ff @(posedge clk) begin
        if (clr) begin
            state               <= S_IDLE;
            test2_enable_re     <= 1'b0;
            test_trig_out_phase <= phase_start;
            rep                 <= 8'd1;
            run_count           <= 16'd0;
            gap_cnt             <= '0;
            sweep_busy          <= 1'b0;
            sweep_done          <= 1'b0;
        end else begin
            test2_enable_re <= 1'b0;
            if (sweep_abort) begin
                state      <= S_IDLE;
                sweep_busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_rise) begin
                            test_trig_out_phase <= phase_start;
                            rep                 <= 8'd1;
                            run_count           <= 16'd0;
                            sweep_done          <= 1'b0;
                            sweep_busy          <= 1'b1;
                            state               <= S_LAUNCH;
                        end
                    end
                    S_LAUNCH: begin
                        // Hold off while the FIFO is full so no result is ever dropped
                        if (fifo_count != CNT_W'(DEPTH)) begin
                            test2_enable_re <= 1'b1;
                            state           <= S_WAIT_DONE;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (done_rise)
                            state <= S_PUSH;
                        else if (wd_expire)
                            state <= S_ERROR;
                    end
                    S_PUSH: begin
                        if (run_count != 16'hFFFF)
                            run_count <= run_count + 16'd1;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_W'(GAP_CYCLES - 1))
                            state <= S_NEXT;
                        else
                            gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                    S_NEXT: begin
                        if (rep < rep_max) begin
                            rep   <= rep + 8'd1;
                            state <= S_LAUNCH;
                        end else if (phase_step == 6'd0 || nxt > {1'b0, phase_stop} || nxt[6]) begin
                            sweep_busy <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            test_trig_out_phase <= nxt[5:0];
                            rep                 <= 8'd1;
                            state               <= S_LAUNCH;
                        end
                    end
                    S_DONE: begin
                        sweep_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                    S_ERROR: begin
                        sweep_busy <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: begin
                        sweep_busy <= 1'b0;
                        state      <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef IP2_TEST3_SWEEP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog over WAIT_DONE and the sticky timeout flag (set on ERROR, cleared by a new start)
    always_ff @(posedge clk) begin
        if (clr) begin
            wd_cnt        <= '0;
            sweep_timeout <= 1'b0;
        end else begin
            if (state == S_LAUNCH)
                wd_cnt <= '0;
            else if (state == S_WAIT_DONE)
                wd_cnt <= wd_cnt + WD_W'(1);
            if (!sweep_abort && state == S_IDLE && start_rise)
                sweep_timeout <= 1'b0;
            else if (!sweep_abort && state == S_ERROR)
                sweep_timeout <= 1'b1;
        end
    end
`else
    // No watchdog: WAIT_DONE waits forever; the comparison keeps TIMEOUT_CYCLES referenced and is constant 0
    assign wd_expire     = 1'b0;
    assign sweep_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // A result is written only from PUSH; an abort in that cycle discards it
    assign push = (state == S_PUSH) && !sweep_abort && !clr;
    assign pop  = fifo_rd_en && (fifo_count != '0) && !clr;

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    // Result storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {test_trig_out_phase, sm_test3_o_dnn_output_1, sm_test3_o_dnn_output_0};
    end

    assign fifo_empty   = (fifo_count == '0);
    assign fifo_full    = (fifo_count == CNT_W'(DEPTH));
    assign fifo_rd_data = fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_ip2_test3_sweep_ctrl.sv
// Testbench for ip2_test3_sweep_ctrl: a behavioural ip2_test3 responder plus
// a phase-list reference model built directly from the sweep rules.
module tb_ip2_test3_sweep_ctrl;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_not, enable, sweep_start, sweep_abort;
    logic [5:0]    phase_start, phase_stop, phase_step;
    logic [7:0]    repeat_count;
    logic          test2_enable_re;
    logic [5:0]    test_trig_out_phase;
    logic          done_sig;
    logic [47:0]   dnn0_sig, dnn1_sig;
    logic          fifo_rd_en;
    logic [101:0]  fifo_rd_data;
    logic          fifo_empty, fifo_full;
    logic [4:0]    fifo_count;
    logic          sweep_busy, sweep_done, sweep_timeout;
    logic [15:0]   run_count;

    // responder state and manual override of the done/dnn inputs
    logic          mdl_done = 1'b0;
    logic [47:0]   md0 = '0, md1 = '0;
    logic          model_on, force_en, force_val;
    logic [47:0]   force_d0, force_d1;
    int            dly, hi;

    int            exp_ph[$];
    int            launch_q[$];
    logic [95:0]   dnn_q[$];
    int            n_checks, n_errors;

    assign done_sig = force_en ? force_val : mdl_done;
    assign dnn0_sig = force_en ? force_d0  : md0;
    assign dnn1_sig = force_en ? force_d1  : md1;

    ip2_test3_sweep_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset_not(reset_not), .enable(enable),
        .sweep_start(sweep_start), .sweep_abort(sweep_abort),
        .phase_start(phase_start), .phase_stop(phase_stop), .phase_step(phase_step),
        .repeat_count(repeat_count),
        .test2_enable_re(test2_enable_re), .test_trig_out_phase(test_trig_out_phase),
        .sm_test3_o_status_done(done_sig),
        .sm_test3_o_dnn_output_0(dnn0_sig), .sm_test3_o_dnn_output_1(dnn1_sig),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_timeout(sweep_timeout),
        .run_count(run_count)
    );

    always #5 clk = ~clk;

    // ip2_test3 stand-in: record every launch, answer with fresh DNN words after a random delay
    always begin
        @(negedge clk);
        if (test2_enable_re) begin
            launch_q.push_back(int'(test_trig_out_phase));
            if (model_on) begin
                dly = $urandom_range(12, 3);
                hi  = $urandom_range(3, 1);
                repeat (dly) @(negedge clk);
                md0 = 48'({$urandom(), $urandom()});
                md1 = 48'({$urandom(), $urandom()});
                dnn_q.push_back({md1, md0});
                mdl_done = 1'b1;
                repeat (hi) @(negedge clk);
                mdl_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected launch phases: each phase repeated max(rc,1) times, stepping until past stop or 63
    task automatic build_phases(input int ps, input int pe, input int st, input int rc);
        int p, n, reps;
        bit more;
        exp_ph.delete();
        reps = (rc == 0) ? 1 : rc;
        p = ps;
        more = 1'b1;
        while (more) begin
            for (int r = 0; r < reps; r++) exp_ph.push_back(p);
            n = p + st;
            if (st == 0 || n > pe || n > 63) more = 1'b0;
            else p = n;
        end
    endtask

    function automatic logic [101:0] exp_word(input int k);
        logic [5:0]  ph;
        logic [95:0] d;
        ph = (k < exp_ph.size()) ? 6'(exp_ph[k]) : 6'h0;
        d  = (k < dnn_q.size()) ? dnn_q[k] : 96'h0;
        return {ph, d};
    endfunction

    task automatic start_sweep(input int ps, input int pe, input int st, input int rc);
        phase_start  = 6'(ps);
        phase_stop   = 6'(pe);
        phase_step   = 6'(st);
        repeat_count = 8'(rc);
        sweep_start  = 1'b1;
        @(negedge clk);
        sweep_start  = 1'b0;
    endtask

    task automatic drain(input int first, input int n);
        int cyc;
        for (int k = first; k < first + n; k++) begin
            cyc = 0;
            while (fifo_empty && cyc < 2000) begin @(negedge clk); cyc++; end
            check("pop_data", 128'(fifo_rd_data), 128'(exp_word(k)));
            fifo_rd_en = 1'b1;
            @(negedge clk);
            fifo_rd_en = 1'b0;
        end
    endtask

    task automatic run_sweep(input int ps, input int pe, input int st, input int rc);
        int cyc;
        build_phases(ps, pe, st, rc);
        launch_q.delete();
        dnn_q.delete();
        start_sweep(ps, pe, st, rc);
        cyc = 0;
        while (!sweep_done && cyc < 5000) begin @(negedge clk); cyc++; end
        check("sweep_done", 128'(sweep_done), 128'(1));
        check("sweep_busy_end", 128'(sweep_busy), 128'(0));
        check("launches", 128'(launch_q.size()), 128'(exp_ph.size()));
        for (int i = 0; i < exp_ph.size() && i < launch_q.size(); i++)
            check("launch_phase", 128'(launch_q[i]), 128'(exp_ph[i]));
        check("run_count", 128'(run_count), 128'(exp_ph.size()));
        check("fifo_count", 128'(fifo_count), 128'(exp_ph.size()));
        drain(0, exp_ph.size());
        check("fifo_empty_end", 128'(fifo_empty), 128'(1));
    endtask

    // Sets up a 21-run sweep and parks it in WAIT_DONE of the 6th run with 5 results queued
    task automatic park_in_sixth_run();
        int cyc;
        build_phases(0, 20, 1, 1);
        launch_q.delete();
        dnn_q.delete();
        start_sweep(0, 20, 1, 1);
        cyc = 0;
        while (launch_q.size() < 6 && cyc < 2000) begin @(negedge clk); cyc++; end
        @(negedge clk);
        check("park_count", 128'(fifo_count), 128'(5));
    endtask

    initial begin
        int cyc, ps, pe, st, rc, tries;
        n_checks = 0; n_errors = 0;
        reset_not = 1'b0; enable = 1'b1; sweep_start = 1'b0; sweep_abort = 1'b0;
        phase_start = 6'd5; phase_stop = 6'd0; phase_step = 6'd0; repeat_count = 8'd0;
        fifo_rd_en = 1'b0; model_on = 1'b1; force_en = 1'b0; force_val = 1'b0;
        force_d0 = '0; force_d1 = '0;
        repeat (3) @(negedge clk);

        check("rst_launch", 128'(test2_enable_re), 128'(0));
        check("rst_phase", 128'(test_trig_out_phase), 128'(5));
        check("rst_empty", 128'(fifo_empty), 128'(1));
        check("rst_count", 128'(fifo_count), 128'(0));
        check("rst_busy", 128'(sweep_busy), 128'(0));
        check("rst_done", 128'(sweep_done), 128'(0));
        check("rst_timeout", 128'(sweep_timeout), 128'(0));
        check("rst_runs", 128'(run_count), 128'(0));
        check("rst_rdata", 128'(fifo_rd_data), 128'(0));
        reset_not = 1'b1;
        @(negedge clk);

        // directed sweeps: repeats, 7-bit overflow end, zero step, start above stop
        run_sweep(2, 8, 3, 2);
        run_sweep(60, 63, 5, 1);
        run_sweep(17, 40, 0, 1);
        run_sweep(9, 4, 3, 3);
        run_sweep(61, 63, 1, 0);

        // randomized sweeps sized to fit the FIFO
        for (int t = 0; t < 6; t++) begin
            tries = 0;
            do begin
                ps = $urandom_range(63, 0);
                pe = $urandom_range(63, 0);
                st = $urandom_range(12, 0);
                rc = $urandom_range(3, 0);
                build_phases(ps, pe, st, rc);
                tries++;
            end while (exp_ph.size() > 14 && tries < 200);
            if (exp_ph.size() > 14) st = 0;
            run_sweep(ps, pe, st, rc);
        end

        // done left high from before the start is not an edge
        model_on = 1'b0; force_en = 1'b1; force_val = 1'b1;
        force_d0 = 48'({$urandom(), $urandom()});
        force_d1 = 48'({$urandom(), $urandom()});
        repeat (3) @(negedge clk);
        start_sweep(3, 3, 1, 1);
        cyc = 0;
        while (!test2_enable_re && cyc < 50) begin @(negedge clk); cyc++; end
        check("held_launch", 128'(test2_enable_re), 128'(1));
        repeat (30) @(negedge clk);
        check("held_no_push", 128'(fifo_count), 128'(0));
        check("held_no_run", 128'(run_count), 128'(0));
        check("held_busy", 128'(sweep_busy), 128'(1));
        force_val = 1'b0;
        repeat (2) @(negedge clk);
        force_val = 1'b1;
        cyc = 0;
        while (!sweep_done && cyc < 100) begin @(negedge clk); cyc++; end
        check("held_done", 128'(sweep_done), 128'(1));
        check("held_count", 128'(fifo_count), 128'(1));
        check("held_runs", 128'(run_count), 128'(1));
        check("held_data", 128'(fifo_rd_data), 128'({6'd3, force_d1, force_d0}));
        fifo_rd_en = 1'b1; @(negedge clk); fifo_rd_en = 1'b0;
        force_en = 1'b0; model_on = 1'b1;
        @(negedge clk);

        // FIFO back-pressure: 20 runs, no reads until full
        build_phases(0, 19, 1, 1);
        launch_q.delete();
        dnn_q.delete();
        start_sweep(0, 19, 1, 1);
        cyc = 0;
        while (!fifo_full && cyc < 3000) begin @(negedge clk); cyc++; end
        repeat (100) @(negedge clk);
        check("bp_full", 128'(fifo_full), 128'(1));
        check("bp_count", 128'(fifo_count), 128'(DEPTH));
        check("bp_launches", 128'(launch_q.size()), 128'(DEPTH));
        check("bp_busy", 128'(sweep_busy), 128'(1));
        check("bp_runs", 128'(run_count), 128'(DEPTH));
        drain(0, 1);
        repeat (100) @(negedge clk);
        check("bp_one_more", 128'(launch_q.size()), 128'(DEPTH + 1));
        check("bp_refull", 128'(fifo_count), 128'(DEPTH));
        drain(1, 19);
        cyc = 0;
        while (!sweep_done && cyc < 2000) begin @(negedge clk); cyc++; end
        check("bp_done", 128'(sweep_done), 128'(1));
        check("bp_total", 128'(run_count), 128'(20));
        check("bp_empty", 128'(fifo_empty), 128'(1));
        for (int i = 0; i < 20 && i < launch_q.size(); i++)
            check("bp_phase", 128'(launch_q[i]), 128'(exp_ph[i]));

        // reset while waiting for done with 5 results queued
        park_in_sixth_run();
        reset_not = 1'b0;
        @(negedge clk);
        reset_not = 1'b1;
        check("mid_rst_empty", 128'(fifo_empty), 128'(1));
        check("mid_rst_count", 128'(fifo_count), 128'(0));
        check("mid_rst_launch", 128'(test2_enable_re), 128'(0));
        check("mid_rst_runs", 128'(run_count), 128'(0));
        check("mid_rst_busy", 128'(sweep_busy), 128'(0));
        check("mid_rst_phase", 128'(test_trig_out_phase), 128'(0));
        repeat (40) @(negedge clk);
        check("mid_rst_no_push", 128'(fifo_count), 128'(0));

        // abort at the same point keeps the queued results and drops the in-flight one
        park_in_sixth_run();
        sweep_abort = 1'b1;
        @(negedge clk);
        sweep_abort = 1'b0;
        check("abort_busy", 128'(sweep_busy), 128'(0));
        check("abort_count", 128'(fifo_count), 128'(5));
        check("abort_runs", 128'(run_count), 128'(5));
        repeat (40) @(negedge clk);
        check("abort_no_push", 128'(fifo_count), 128'(5));
        check("abort_no_done", 128'(sweep_done), 128'(0));
        check("abort_no_relaunch", 128'(launch_q.size()), 128'(6));
        drain(0, 5);
        check("abort_empty", 128'(fifo_empty), 128'(1));

`ifdef IP2_TEST3_SWEEP_TIMEOUT_EN
        // watchdog: done never arrives
        model_on = 1'b0; force_en = 1'b1; force_val = 1'b0;
        start_sweep(7, 7, 1, 1);
        cyc = 0;
        while (!test2_enable_re && cyc < 50) begin @(negedge clk); cyc++; end
        cyc = 0;
        while (sweep_busy && cyc < 300) begin @(negedge clk); cyc++; end
        check("wd_cycles", 128'(cyc), 128'(101));
        check("wd_timeout", 128'(sweep_timeout), 128'(1));
        check("wd_no_push", 128'(fifo_count), 128'(0));
        check("wd_no_done", 128'(sweep_done), 128'(0));
        force_en = 1'b0; model_on = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
